// File: rtl/mcb_arb_if.sv
// Bundle of the requester command/strobe ports and the shared MCB burst-command port.
// slave = arbiter view, master = requesters plus MCB back end.
interface mcb_arb_if #(
  parameter int NP = 4,
  parameter int AW = 24
);
  logic [NP-1:0]    p_req;
  logic [NP-1:0]    p_wr_n;
  logic [2*NP-1:0]  p_bl;
  logic [AW*NP-1:0] p_addr;
  logic [NP-1:0]    p_ack;
  logic [NP-1:0]    p_rdat_vld;
  logic [NP-1:0]    p_wdat_req;
  logic             mcb_bb;
  logic             mcb_wr_n;
  logic [1:0]       mcb_bl;
  logic [AW-1:0]    mcb_addr;
  logic             mcb_busy;
  logic             mcb_rdat_vld;
  logic             mcb_wdat_req;
  logic             err_stray;

  modport slave (
    input  p_req, p_wr_n, p_bl, p_addr, mcb_busy, mcb_rdat_vld, mcb_wdat_req,
    output p_ack, p_rdat_vld, p_wdat_req, mcb_bb, mcb_wr_n, mcb_bl, mcb_addr, err_stray
  );

  modport master (
    output p_req, p_wr_n, p_bl, p_addr, mcb_busy, mcb_rdat_vld, mcb_wdat_req,
    input  p_ack, p_rdat_vld, p_wdat_req, mcb_bb, mcb_wr_n, mcb_bl, mcb_addr, err_stray
  );
endinterface

// File: rtl/mcb_arb.sv
// mcb_arb: round-robin arbiter for the MCB burst-command port; MCB_ARB_PRIO_EN gives port 0 fixed priority.
// Grant/mcb_bb one cycle after a request in IDLE; mcb_busy stalls arbitration in IDLE and burst retirement in DRAIN.
module mcb_arb #(
  parameter int NP = 4,
  parameter int AW = 24,
  parameter int PW = 2
) (
  input logic     mcb_clk,
  input logic     mcb_rst_n,
  mcb_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] owner;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          win_vld;
  logic [3:0]    cnt;
  logic          wr_n_q;
  logic [1:0]    bl_q;
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic          in_data;
  logic          rd_hit;
  logic          wr_hit;
  logic          stray;
  logic [NP-1:0] owner_oh;

  // Search starts one past the last owner so every requester is served in turn.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NP; i++) begin
      logic [PW-1:0] idx_p;
      idx_p = PW'((int'(ptr) + i) % NP);
      if (!win_vld && bus.p_req[idx_p]) begin
        win_vld = 1'b1;
        win     = idx_p;
      end
    end
`ifdef MCB_ARB_PRIO_EN
    if (bus.p_req[0]) begin
      win     = '0;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld && !bus.mcb_busy) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    state_nxt = DRAIN;
      DRAIN:   if (cnt == 4'd0 && !bus.mcb_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes only count while a burst of the matching direction still has beats left.
  assign in_data  = ((state == HOLD) || (state == DRAIN)) && (cnt != 4'd0);
  assign rd_hit   = in_data &&  wr_n_q && bus.mcb_rdat_vld;
  assign wr_hit   = in_data && !wr_n_q && bus.mcb_wdat_req;
  assign stray    = (bus.mcb_rdat_vld && !rd_hit) || (bus.mcb_wdat_req && !wr_hit);
  assign owner_oh = {{(NP-1){1'b0}}, 1'b1} << owner;

  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= PW'(NP-1);
      cnt    <= 4'd0;
      wr_n_q <= 1'b0;
      bl_q   <= 2'b00;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == ISSUE) begin
        owner  <= win;
        wr_n_q <= bus.p_wr_n[win];
        bl_q   <= bus.p_bl[2*win +: 2];
        addr_q <= bus.p_addr[AW*win +: AW];
      end
      // Reserved burst codes 1x are issued as 8 beats.
      if (state == ISSUE) begin
        cnt <= (bl_q == 2'b00) ? 4'd4 : 4'd8;
        ptr <= owner;
      end else if (rd_hit || wr_hit) begin
        cnt <= cnt - 4'd1;
      end
      if (stray) err_q <= 1'b1;
    end
  end

  assign bus.mcb_bb     = (state == ISSUE);
  assign bus.p_ack      = (state == ISSUE) ? owner_oh : '0;
  assign bus.p_rdat_vld = rd_hit ? owner_oh : '0;
  assign bus.p_wdat_req = wr_hit ? owner_oh : '0;
  assign bus.mcb_wr_n   = wr_n_q;
  assign bus.mcb_bl     = bl_q;
  assign bus.mcb_addr   = addr_q;
  assign bus.err_stray  = err_q;

endmodule

// File: tb/tb_mcb_arb.sv
// Directed bench for mcb_arb: grant latency, round-robin order, busy stall, stray strobes, reset mid-burst, priority.
module tb_mcb_arb;
  localparam int NP = 4;
  localparam int AW = 24;
  localparam int PW = 2;

  logic mcb_clk = 1'b0;
  logic mcb_rst_n = 1'b0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  mcb_arb_if #(.NP(NP), .AW(AW)) bus ();

  mcb_arb #(.NP(NP), .AW(AW), .PW(PW)) dut (
    .mcb_clk   (mcb_clk),
    .mcb_rst_n (mcb_rst_n),
    .bus       (bus)
  );

  always #5 mcb_clk = ~mcb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mcb_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"},      32'(bus.p_ack), 32'h0);
    chk({tag, "_rdat_vld"}, 32'(bus.p_rdat_vld), 32'h0);
    chk({tag, "_wdat_req"}, 32'(bus.p_wdat_req), 32'h0);
    chk({tag, "_bb"},       32'(bus.mcb_bb), 32'h0);
    chk({tag, "_wr_n"},     32'(bus.mcb_wr_n), 32'h0);
    chk({tag, "_bl"},       32'(bus.mcb_bl), 32'h0);
    chk({tag, "_addr"},     32'(bus.mcb_addr), 32'h0);
    chk({tag, "_err"},      32'(bus.err_stray), 32'h0);
  endtask

  task automatic set_port(input int p, input logic wr_n, input logic [1:0] bl, input logic [AW-1:0] addr);
    bus.p_wr_n[p]         = wr_n;
    bus.p_bl[2*p +: 2]    = bl;
    bus.p_addr[AW*p +: AW] = addr;
  endtask

  task automatic wait_bb(input int max, input string tag);
    int n;
    n = 0;
    while (bus.mcb_bb !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.mcb_bb), 32'h1);
  endtask

  // Entered with the arbiter in ISSUE; returns with it back in IDLE.
  task automatic burst(input int p, input bit rd, input int beats, input string tag);
    tick();
    chk({tag, "_bb_one_cycle"}, 32'(bus.mcb_bb), 32'h0);
    for (int b = 0; b < beats; b++) begin
      if (rd) bus.mcb_rdat_vld = 1'b1;
      else    bus.mcb_wdat_req = 1'b1;
      #1;
      if (rd) chk({tag, "_beat"}, 32'(bus.p_rdat_vld), 32'(1 << p));
      else    chk({tag, "_beat"}, 32'(bus.p_wdat_req), 32'(1 << p));
      tick();
      bus.mcb_rdat_vld = 1'b0;
      bus.mcb_wdat_req = 1'b0;
    end
    tick();
  endtask

  initial begin
    int bb_seen;
    int exp_p;
    bus.p_req        = '0;
    bus.p_wr_n       = '0;
    bus.p_bl         = '0;
    bus.p_addr       = '0;
    bus.mcb_busy     = 1'b0;
    bus.mcb_rdat_vld = 1'b0;
    bus.mcb_wdat_req = 1'b0;

    // Reset state
    mcb_rst_n = 1'b0;
    tick();
    tick();
    chk_zero_outputs("rst");
    mcb_rst_n = 1'b1;

    // Single read burst from port 0, 8 beats
    set_port(0, 1'b1, 2'b01, 24'h000123);
    bus.p_req = 4'b0001;
    tick();
    chk("t1_bb",   32'(bus.mcb_bb), 32'h1);
    chk("t1_ack",  32'(bus.p_ack), 32'h1);
    chk("t1_wr_n", 32'(bus.mcb_wr_n), 32'h1);
    chk("t1_bl",   32'(bus.mcb_bl), 32'h1);
    chk("t1_addr", 32'(bus.mcb_addr), 32'h000123);
    bus.p_req = 4'b0000;
    burst(0, 1'b1, 8, "t1_rd");
    // Back in IDLE: a new request is granted on the very next edge
    set_port(1, 1'b0, 2'b00, 24'h0000AA);
    bus.p_req = 4'b0010;
    tick();
    chk("t1_idle_bb",  32'(bus.mcb_bb), 32'h1);
    chk("t1_idle_ack", 32'(bus.p_ack), 32'h2);
    bus.p_req = 4'b0000;
    burst(1, 1'b0, 4, "t1_wr");
    chk("t1_no_err", 32'(bus.err_stray), 32'h0);

    // All four ports writing continuously: order 0,1,2,3,0
    mcb_rst_n = 1'b0;
    tick();
    mcb_rst_n = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 2'b00, AW'(24'h000100 * (p + 1)));
    bus.p_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_p = k % NP;
      wait_bb(8, "t2_bb");
      chk("t2_ack",  32'(bus.p_ack), 32'(1 << exp_p));
      chk("t2_addr", 32'(bus.mcb_addr), 32'(24'h000100 * (exp_p + 1)));
      chk("t2_bl",   32'(bus.mcb_bl), 32'h0);
      burst(exp_p, 1'b0, 4, "t2_wr");
    end
    bus.p_req = 4'b0000;

    // Busy held for 20 cycles stalls the grant
    set_port(2, 1'b1, 2'b00, 24'h0000C0);
    bus.mcb_busy = 1'b1;
    bus.p_req    = 4'b0100;
    bb_seen = 0;
    repeat (20) begin
      tick();
      if (bus.mcb_bb === 1'b1) bb_seen++;
    end
    chk("t3_busy_nobb", 32'(bb_seen), 32'h0);
    bus.mcb_busy = 1'b0;
    tick();
    chk("t3_bb",  32'(bus.mcb_bb), 32'h1);
    chk("t3_ack", 32'(bus.p_ack), 32'h4);
    bus.p_req = 4'b0000;
    burst(2, 1'b1, 4, "t3_rd");

    // Stray read strobe in IDLE
    chk("t4_err_pre", 32'(bus.err_stray), 32'h0);
    bus.mcb_rdat_vld = 1'b1;
    #1;
    chk("t4_no_route", 32'(bus.p_rdat_vld), 32'h0);
    tick();
    bus.mcb_rdat_vld = 1'b0;
    chk("t4_err", 32'(bus.err_stray), 32'h1);
    repeat (5) tick();
    chk("t4_err_sticky", 32'(bus.err_stray), 32'h1);

    // Reset after 3 of 8 beats; pointer must return to NP-1
    set_port(2, 1'b1, 2'b01, 24'h0002B0);
    bus.p_req = 4'b0100;
    tick();
    chk("t5_ack", 32'(bus.p_ack), 32'h4);
    bus.p_req = 4'b0000;
    tick();
    for (int b = 0; b < 3; b++) begin
      bus.mcb_rdat_vld = 1'b1;
      #1;
      chk("t5_beat", 32'(bus.p_rdat_vld), 32'h4);
      tick();
      bus.mcb_rdat_vld = 1'b0;
    end
    mcb_rst_n = 1'b0;
    bus.mcb_rdat_vld = 1'b1;
    tick();
    chk_zero_outputs("t5_rst");
    bus.mcb_rdat_vld = 1'b0;
    mcb_rst_n = 1'b1;
    set_port(2, 1'b1, 2'b00, 24'h0002C0);
    set_port(3, 1'b1, 2'b00, 24'h0003C0);
    bus.p_req = 4'b1100;
    tick();
    chk("t5_ptr_ack",  32'(bus.p_ack), 32'h4);
    chk("t5_ptr_addr", 32'(bus.mcb_addr), 32'h0002C0);
    bus.p_req = 4'b0000;
    burst(2, 1'b1, 4, "t5_rd");
    chk("t5_no_err", 32'(bus.err_stray), 32'h0);

    // Ports 0 and 3 requesting continuously
    mcb_rst_n = 1'b0;
    tick();
    mcb_rst_n = 1'b1;
    set_port(0, 1'b0, 2'b00, 24'h000010);
    set_port(3, 1'b0, 2'b00, 24'h000030);
    bus.p_req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
`ifdef MCB_ARB_PRIO_EN
      exp_p = 0;
`else
      exp_p = (k % 2 == 0) ? 0 : 3;
`endif
      wait_bb(8, "t6_bb");
      chk("t6_ack", 32'(bus.p_ack), 32'(1 << exp_p));
      burst(exp_p, 1'b0, 4, "t6_wr");
    end
    bus.p_req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
